// File: rtl/stream_in_matrix_pp_hs.sv
// Ping-pong serial-to-matrix converter: fills one R x C bank while the other is offered downstream.
// Optional column-major fill is enabled by defining STREAM_MATRIX_COLMAJOR_EN.
module stream_in_matrix_pp_hs #(
    parameter int BITS = 8,
    parameter int R    = 3,
    parameter int C    = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [BITS-1:0]                  a,
`ifdef STREAM_MATRIX_COLMAJOR_EN
    input  logic                             col_major,
`endif
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [R-1:0][C-1:0][BITS-1:0]    c,
    output logic                             out_bank
);

    localparam int RW = (R > 1) ? $clog2(R) : 1;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(R - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(C - 1);

    logic [1:0][R-1:0][C-1:0][BITS-1:0] bank;
    logic [1:0]    full;
    logic          wr_sel;
    logic          rd_sel;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          in_fire;
    logic          out_fire;
    logic          first;
    logic          last;
    logic          fill_col;

    // Handshake: a transfer happens on a rising edge where valid && ready; valid never
    // waits on ready, and ready/valid here are pure decodes of the full flags.
    assign in_ready  = !full[wr_sel];
    assign out_valid = full[rd_sel];
    assign c         = bank[rd_sel];
    assign out_bank  = rd_sel;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // The last element sits at [R-1][C-1] in either fill order.
    assign first = (row == '0) && (col == '0);
    assign last  = (row == ROW_LAST) && (col == COL_LAST);

`ifdef STREAM_MATRIX_COLMAJOR_EN
    logic order_q;
    // The first element uses the live port; the rest of the matrix follows the latched copy.
    assign fill_col = first ? col_major : order_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            order_q <= 1'b0;
        end else if (in_fire && first) begin
            order_q <= col_major;
        end
    end
`else
    assign fill_col = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank   <= '0;
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            row    <= '0;
            col    <= '0;
        end else begin
            if (in_fire) begin
                bank[wr_sel][row][col] <= a;
                if (last) begin
                    row            <= '0;
                    col            <= '0;
                    full[wr_sel]   <= 1'b1;
                    wr_sel         <= ~wr_sel;
                end else if (fill_col) begin
                    if (row == ROW_LAST) begin
                        row <= '0;
                        col <= col + CW'(1);
                    end else begin
                        row <= row + RW'(1);
                    end
                end else begin
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end
            end
            // Both fires can land together only on different banks, so these never collide.
            if (out_fire) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= ~rd_sel;
            end
        end
    end

endmodule

// File: tb/tb_stream_in_matrix_pp_hs.sv
// Directed bench for stream_in_matrix_pp_hs: 3x3, 2x4 (random gaps) and 1x1 instances.
// Column-major steps run when STREAM_MATRIX_COLMAJOR_EN is defined.
module tb_stream_in_matrix_pp_hs;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // 3x3 instance
    logic             in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b0, out_bank0;
    logic [7:0]       a0 = '0;
    logic             col_major0 = 1'b0;
    logic [2:0][2:0][7:0] c0;

    // 2x4 instance
    logic             in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0, out_bank1;
    logic [7:0]       a1 = '0;
    logic             col_major1 = 1'b0;
    logic [1:0][3:0][7:0] c1;

    // 1x1 instance
    logic             in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0, out_bank2;
    logic [7:0]       a2 = '0;
    logic             col_major2 = 1'b0;
    logic [0:0][0:0][7:0] c2;

    stream_in_matrix_pp_hs #(.BITS(8), .R(3), .C(3)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .a(a0),
`ifdef STREAM_MATRIX_COLMAJOR_EN
        .col_major(col_major0),
`endif
        .out_valid(out_valid0), .out_ready(out_ready0), .c(c0), .out_bank(out_bank0)
    );

    stream_in_matrix_pp_hs #(.BITS(8), .R(2), .C(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1),
`ifdef STREAM_MATRIX_COLMAJOR_EN
        .col_major(col_major1),
`endif
        .out_valid(out_valid1), .out_ready(out_ready1), .c(c1), .out_bank(out_bank1)
    );

    stream_in_matrix_pp_hs #(.BITS(8), .R(1), .C(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2),
`ifdef STREAM_MATRIX_COLMAJOR_EN
        .col_major(col_major2),
`endif
        .out_valid(out_valid2), .out_ready(out_ready2), .c(c2), .out_bank(out_bank2)
    );

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    // 3x3 row-major matrix whose element k (flat index r*3+c) equals base+k.
    function automatic logic [71:0] rm9(input int base);
        logic [71:0] m;
        m = '0;
        for (int i = 0; i < 9; i++) m[i*8 +: 8] = 8'(base + i);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [7:0] v);
        int n;
        n = 0;
        in_valid0 = 1'b1;
        a0 = v;
        while (!in_ready0 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) timeout("push0");
        tick();
        in_valid0 = 1'b0;
    endtask

    task automatic push1(input logic [7:0] v);
        int n;
        n = 0;
        in_valid1 = 1'b1;
        a1 = v;
        while (!in_ready1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) timeout("push1");
        tick();
        in_valid1 = 1'b0;
    endtask

    task automatic push2(input logic [7:0] v);
        in_valid2 = 1'b1;
        a2 = v;
        if (!in_ready2) timeout("push2");
        tick();
        in_valid2 = 1'b0;
    endtask

    logic [63:0] exp_q[$];
    int          got1;

    initial begin
        // Reset
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_in_ready", 72'(in_ready0), 72'd1);
        check("rst_out_valid", 72'(out_valid0), 72'd0);
        check("rst_c", 72'(c0), 72'd0);
        check("rst_out_bank", 72'(out_bank0), 72'd0);

        // Row-major 1..9 with consumer always ready
        out_ready0 = 1'b1;
        for (int i = 1; i <= 8; i++) push0(8'(i));
        check("rm_no_early_valid", 72'(out_valid0), 72'd0);
        push0(8'd9);
        check("rm_out_valid", 72'(out_valid0), 72'd1);
        check("rm_c", 72'(c0), 72'h09_08_07_06_05_04_03_02_01);
        check("rm_out_bank", 72'(out_bank0), 72'd0);
        tick();
        check("rm_valid_one_cycle", 72'(out_valid0), 72'd0);
        check("rm_bank_toggle", 72'(out_bank0), 72'd1);

`ifdef STREAM_MATRIX_COLMAJOR_EN
        // Col-major 1..9; flipping col_major mid-matrix must be ignored
        col_major0 = 1'b1;
        push0(8'd1);
        col_major0 = 1'b0;
        for (int i = 2; i <= 9; i++) push0(8'(i));
        check("cm_out_valid", 72'(out_valid0), 72'd1);
        check("cm_c", 72'(c0), 72'h09_06_03_08_05_02_07_04_01);
        check("cm_out_bank", 72'(out_bank0), 72'd1);
`else
        for (int i = 10; i <= 18; i++) push0(8'(i));
        check("rm2_out_valid", 72'(out_valid0), 72'd1);
        check("rm2_c", 72'(c0), 72'h12_11_10_0f_0e_0d_0c_0b_0a);
        check("rm2_out_bank", 72'(out_bank0), 72'd1);
`endif
        tick();
        check("m2_drained", 72'(out_valid0), 72'd0);

        // Backpressure: consumer stalled, two banks fill
        out_ready0 = 1'b0;
        for (int i = 1; i <= 18; i++) push0(8'(i));
        check("bp_in_ready_low", 72'(in_ready0), 72'd0);
        check("bp_c_bank0", 72'(c0), rm9(1));
        check("bp_out_bank0", 72'(out_bank0), 72'd0);
        in_valid0 = 1'b1;
        a0 = 8'd19;
        tick();
        tick();
        tick();
        check("bp_stall_ready", 72'(in_ready0), 72'd0);
        check("bp_stall_c", 72'(c0), rm9(1));
        check("bp_stall_valid", 72'(out_valid0), 72'd1);
        out_ready0 = 1'b1;
        tick();
        out_ready0 = 1'b0;
        check("bp_c_bank1", 72'(c0), rm9(10));
        check("bp_out_bank1", 72'(out_bank0), 72'd1);
        check("bp_in_ready_rise", 72'(in_ready0), 72'd1);
        for (int i = 19; i <= 27; i++) push0(8'(i));
        check("bp_full_again", 72'(in_ready0), 72'd0);
        check("bp_hold_bank1", 72'(c0), rm9(10));
        out_ready0 = 1'b1;
        tick();
        out_ready0 = 1'b0;
        check("bp_m3_c", 72'(c0), rm9(19));
        check("bp_m3_bank", 72'(out_bank0), 72'd0);
        out_ready0 = 1'b1;
        tick();
        check("bp_drained", 72'(out_valid0), 72'd0);

        // Reset after element 5 discards the partial matrix
        for (int i = 1; i <= 5; i++) push0(8'(i));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_out_valid", 72'(out_valid0), 72'd0);
        check("mrst_in_ready", 72'(in_ready0), 72'd1);
        check("mrst_c", 72'(c0), 72'd0);
        check("mrst_out_bank", 72'(out_bank0), 72'd0);
        for (int i = 0; i < 8; i++) push0(8'(8'h21 + i));
        check("mrst_no_early", 72'(out_valid0), 72'd0);
        push0(8'h29);
        check("mrst_fresh_c", 72'(c0), rm9(8'h21));
        check("mrst_fresh_bank", 72'(out_bank0), 72'd0);

        // 2x4 with random input gaps and random consumer stalls, 5 matrices
        got1 = 0;
        fork
            begin
                logic [63:0] m;
                for (int mi = 0; mi < 5; mi++) begin
                    m = '0;
                    for (int k = 0; k < 8; k++) begin
                        logic [7:0] v;
                        v = 8'($urandom_range(0, 255));
                        m[k*8 +: 8] = v;
                        while ($urandom_range(0, 1) == 0) tick();
                        if (k == 7) exp_q.push_back(m);
                        push1(v);
                    end
                end
            end
            begin
                logic        hold;
                logic [63:0] prev_c;
                hold = 1'b0;
                prev_c = '0;
                for (int cyc = 0; cyc < 3000 && got1 < 5; cyc++) begin
                    if (hold) check("rnd_c_stable", 72'(c1), 72'(prev_c));
                    out_ready1 = 1'($urandom_range(0, 1));
                    if (out_valid1 && out_ready1) begin
                        if (exp_q.size() == 0) begin
                            timeout("rnd_unexpected_output");
                        end else begin
                            check("rnd_matrix", 72'(c1), 72'(exp_q.pop_front()));
                        end
                        got1++;
                    end
                    hold = out_valid1 && !out_ready1;
                    prev_c = c1;
                    tick();
                end
                out_ready1 = 1'b0;
                if (got1 < 5) timeout("rnd_matrix_count");
            end
        join

        // 1x1: every element is a full matrix
        out_ready2 = 1'b1;
        push2(8'd7);
        check("one_valid_7", 72'(out_valid2), 72'd1);
        check("one_c_7", 72'(c2), 72'd7);
        check("one_bank_7", 72'(out_bank2), 72'd0);
        push2(8'd8);
        check("one_valid_8", 72'(out_valid2), 72'd1);
        check("one_c_8", 72'(c2), 72'd8);
        check("one_bank_8", 72'(out_bank2), 72'd1);
        push2(8'd9);
        check("one_valid_9", 72'(out_valid2), 72'd1);
        check("one_c_9", 72'(c2), 72'd9);
        check("one_bank_9", 72'(out_bank2), 72'd0);
        tick();
        check("one_drained", 72'(out_valid2), 72'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
